// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multi-cycle sequencer of the 16-bit RISC datapath.
// Contents:
//   state_t      - sequencer state encoding (IDLE..HALT = 0..7, visible on the state port)
//   OP_*         - opcode values carried in IR[15:12]
//   ALU_*        - ALU control codes driven on alu_ctrl
//   is_mem_state - true for the states that hold the shared memory port
package multicycle_control_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_BRANCH = 3'd6,
        S_HALT   = 3'd7
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_ADDI = 4'b0100;
    localparam logic [3:0] OP_LW   = 4'b0101;
    localparam logic [3:0] OP_SW   = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_BEQ  = 4'b1000;
    localparam logic [3:0] OP_BNE  = 4'b1001;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // FETCH and MEM are the only states that wait on mem_ready.
    function automatic logic is_mem_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEM);
    endfunction

endpackage

// File: rtl/multicycle_control_op_decode.sv
// op_decode: purely combinational opcode classifier.
// Ports:
//   op        in  4  opcode from IR[15:12]
//   is_rtype  out 1  add/sub/and/or/slt (write-back to rd)
//   is_addi   out 1  add immediate
//   is_lw     out 1  load word
//   is_sw     out 1  store word
//   is_beq    out 1  branch if equal
//   is_bne    out 1  branch if not equal
//   illegal   out 1  opcode 1010-1111
//   alu_ctrl  out 3  ALU operation used in EXEC (address arithmetic uses add)
module op_decode
    import multicycle_control_pkg::*;
(
    input  logic [3:0] op,
    output logic       is_rtype,
    output logic       is_addi,
    output logic       is_lw,
    output logic       is_sw,
    output logic       is_beq,
    output logic       is_bne,
    output logic       illegal,
    output logic [2:0] alu_ctrl
);

    always_comb begin
        is_rtype = 1'b0;
        is_addi  = 1'b0;
        is_lw    = 1'b0;
        is_sw    = 1'b0;
        is_beq   = 1'b0;
        is_bne   = 1'b0;
        illegal  = 1'b0;
        alu_ctrl = ALU_AND;
        case (op)
            OP_ADD:  begin is_rtype = 1'b1; alu_ctrl = ALU_ADD; end
            OP_SUB:  begin is_rtype = 1'b1; alu_ctrl = ALU_SUB; end
            OP_AND:  begin is_rtype = 1'b1; alu_ctrl = ALU_AND; end
            OP_OR:   begin is_rtype = 1'b1; alu_ctrl = ALU_OR;  end
            OP_SLT:  begin is_rtype = 1'b1; alu_ctrl = ALU_SLT; end
            OP_ADDI: begin is_addi  = 1'b1; alu_ctrl = ALU_ADD; end
            OP_LW:   begin is_lw    = 1'b1; alu_ctrl = ALU_ADD; end
            OP_SW:   begin is_sw    = 1'b1; alu_ctrl = ALU_ADD; end
            OP_BEQ:  begin is_beq   = 1'b1; alu_ctrl = ALU_SUB; end
            OP_BNE:  begin is_bne   = 1'b1; alu_ctrl = ALU_SUB; end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: multi-cycle sequencer for the 16-bit RISC datapath.
// Walks each instruction through FETCH/DECODE/EXEC/MEM/WB/BRANCH, sharing one
// memory port between instruction fetch and data access.
// Ports:
//   clk, rst (async, active-high)
//   run        in   start/continue fetching; looked at only on instruction boundaries
//   op         in   IR[15:12], stable from DECODE to end of instruction
//   zero       in   ALU zero flag (used in BRANCH)
//   mem_ready  in   memory completes the current access this cycle
//   mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src, alu_ctrl,
//   reg_dst, mem_to_reg, reg_write   out  datapath strobes (combinational)
//   state      out  current state encoding
//   illegal    out  sticky undefined-opcode flag
//   timeout    out  sticky memory-wait fault flag
//   retired    out  completed-instruction counter (wraps)
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int WAIT_LIMIT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [3:0]       op,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             iord,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic             alu_src,
    output logic [2:0]       alu_ctrl,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic [2:0]       state,
    output logic             illegal,
    output logic             timeout,
    output logic [CNT_W-1:0] retired
);

    localparam int WAIT_W = $clog2(WAIT_LIMIT + 1);

    state_t             state_reg;
    logic [WAIT_W-1:0]  wait_reg;
    logic [CNT_W-1:0]   retired_reg;
    logic               illegal_reg;
    logic               timeout_reg;

    logic       is_rtype, is_addi, is_lw, is_sw, is_beq, is_bne, dec_illegal;
    logic [2:0] dec_alu_ctrl;

    op_decode u_op_decode (
        .op       (op),
        .is_rtype (is_rtype),
        .is_addi  (is_addi),
        .is_lw    (is_lw),
        .is_sw    (is_sw),
        .is_beq   (is_beq),
        .is_bne   (is_bne),
        .illegal  (dec_illegal),
        .alu_ctrl (dec_alu_ctrl)
    );

    logic   waiting;
    logic   wait_hit;
    logic   retire;
    state_t after_retire;

    // wait_reg counts waiting cycles already seen, so the WAIT_LIMIT-th one
    // is the cycle where the count equals WAIT_LIMIT-1.
    assign waiting      = is_mem_state(state_reg) && !mem_ready;
    assign wait_hit     = waiting && (wait_reg == WAIT_W'(WAIT_LIMIT - 1));
    assign after_retire = run ? S_FETCH : S_IDLE;

    // Datapath strobes and the retire event.
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        alu_src    = 1'b0;
        alu_ctrl   = ALU_AND;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        retire     = 1'b0;
        case (state_reg)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                end
            end
            S_EXEC: begin
                alu_ctrl = dec_alu_ctrl;
                alu_src  = is_addi | is_lw | is_sw;
            end
            S_MEM: begin
                mem_req  = 1'b1;
                iord     = 1'b1;
                alu_ctrl = ALU_ADD;
                alu_src  = 1'b1;
                mem_we   = is_sw;
                retire   = mem_ready & is_sw;
            end
            S_WB: begin
                reg_write  = 1'b1;
                reg_dst    = is_rtype;
                mem_to_reg = is_lw;
                retire     = 1'b1;
            end
            S_BRANCH: begin
                alu_ctrl = ALU_SUB;
                pc_src   = 1'b1;
                pc_write = (is_beq & zero) | (is_bne & ~zero);
                retire   = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= S_IDLE;
            wait_reg    <= '0;
            retired_reg <= '0;
            illegal_reg <= 1'b0;
            timeout_reg <= 1'b0;
        end else begin
            // Any exit from the waiting state (ready, fault) clears the count.
            if (waiting && !wait_hit)
                wait_reg <= wait_reg + 1'b1;
            else
                wait_reg <= '0;

            if (retire)
                retired_reg <= retired_reg + 1'b1;

            case (state_reg)
                S_IDLE: begin
                    if (run)
                        state_reg <= S_FETCH;
                end
                S_FETCH: begin
                    if (mem_ready) begin
                        state_reg <= S_DECODE;
                    end else if (wait_hit) begin
                        state_reg   <= S_HALT;
                        timeout_reg <= 1'b1;
                    end
                end
                S_DECODE: begin
                    if (dec_illegal) begin
                        state_reg   <= S_HALT;
                        illegal_reg <= 1'b1;
                    end else if (is_beq || is_bne) begin
                        state_reg <= S_BRANCH;
                    end else begin
                        state_reg <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    state_reg <= (is_lw || is_sw) ? S_MEM : S_WB;
                end
                S_MEM: begin
                    if (mem_ready) begin
                        state_reg <= is_sw ? after_retire : S_WB;
                    end else if (wait_hit) begin
                        state_reg   <= S_HALT;
                        timeout_reg <= 1'b1;
                    end
                end
                S_WB:     state_reg <= after_retire;
                S_BRANCH: state_reg <= after_retire;
                S_HALT:   state_reg <= S_HALT;
                default:  state_reg <= S_IDLE;
            endcase
        end
    end

    assign state   = state_reg;
    assign illegal = illegal_reg;
    assign timeout = timeout_reg;
    assign retired = retired_reg;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control. An instruction-level model expands
// each issued instruction into its expected per-cycle trace (state, strobes,
// flags, retired count) and queues it; a negedge monitor pops and compares.
module tb_multicycle_control;

    localparam int CNT_W      = 4;
    localparam int WAIT_LIMIT = 4;

    localparam logic [2:0] ST_IDLE = 3'd0, ST_FETCH = 3'd1, ST_DECODE = 3'd2, ST_EXEC = 3'd3,
                           ST_MEM = 3'd4, ST_WB = 3'd5, ST_BRANCH = 3'd6, ST_HALT = 3'd7;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic run = 1'b0;
    logic zero = 1'b0;
    logic mem_ready = 1'b0;
    logic [3:0] op = 4'd0;

    logic mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src;
    logic [2:0] alu_ctrl;
    logic reg_dst, mem_to_reg, reg_write;
    logic [2:0] state;
    logic illegal, timeout;
    logic [CNT_W-1:0] retired;

    multicycle_control #(.CNT_W(CNT_W), .WAIT_LIMIT(WAIT_LIMIT)) dut (
        .clk(clk), .rst(rst), .run(run), .op(op), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
        .pc_write(pc_write), .pc_src(pc_src), .alu_src(alu_src), .alu_ctrl(alu_ctrl),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .state(state), .illegal(illegal), .timeout(timeout), .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]       st;
        logic [12:0]      strb;
        logic             ill;
        logic             tmo;
        logic [CNT_W-1:0] ret;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    checks = 0;
    int    failures = 0;
    int    n_seen = 0;

    // Model of the architectural status seen by the outside world.
    int m_ret  = 0;
    bit m_ill  = 0;
    bit m_tmo  = 0;
    bit m_idle = 1;
    bit m_halt = 0;

    function automatic logic [12:0] sb(input bit mreq, input bit we, input bit ior, input bit irw,
                                       input bit pcw, input bit pcs, input bit asrc,
                                       input logic [2:0] aluc, input bit rd, input bit m2r,
                                       input bit rw);
        return {mreq, we, ior, irw, pcw, pcs, asrc, aluc, rd, m2r, rw};
    endfunction

    function automatic bit rb();
        return bit'($urandom_range(0, 1));
    endfunction

    function automatic logic [3:0] rop();
        return 4'($urandom_range(0, 15));
    endfunction

    // ALU operation each opcode needs in EXEC.
    function automatic logic [2:0] alu_for(input logic [3:0] o);
        case (o)
            4'd1:    return 3'b110;
            4'd2:    return 3'b000;
            4'd3:    return 3'b001;
            4'd7:    return 3'b111;
            default: return 3'b010;
        endcase
    endfunction

    // One clock: drive inputs just after the rising edge and queue what the
    // DUT must show during this cycle.
    task automatic drive(input bit r, input bit rdy, input logic [3:0] o, input bit z,
                         input logic [2:0] st, input logic [12:0] strb, input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        rst = 1'b0;
        run = r;
        mem_ready = rdy;
        op = o;
        zero = z;
        e.st = st;
        e.strb = strb;
        e.ill = m_ill;
        e.tmo = m_tmo;
        e.ret = CNT_W'(m_ret % (1 << CNT_W));
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic do_reset();
        exp_t e;
        @(posedge clk);
        #1;
        rst = 1'b1;
        run = rb();
        mem_ready = rb();
        op = rop();
        m_ret = 0; m_ill = 0; m_tmo = 0; m_halt = 0; m_idle = 1;
        e.st = ST_IDLE; e.strb = '0; e.ill = 1'b0; e.tmo = 1'b0; e.ret = '0;
        exp_q.push_back(e);
        tag_q.push_back("reset");
        drive(1'b0, rb(), rop(), rb(), ST_IDLE, '0, "reset_release");
    endtask

    task automatic halt_cycles(input int n);
        for (int i = 0; i < n; i++)
            drive(rb(), rb(), rop(), rb(), ST_HALT, '0, "halt");
    endtask

    // Expand one instruction into its expected cycle-by-cycle trace.
    task automatic issue(input logic [3:0] o, input bit z, input int fw, input int mw,
                         input bit run_end, input bit rst_in_mem);
        bit is_r, is_lw, is_sw, taken;
        is_r  = (o <= 4'd3) || (o == 4'd7);
        is_lw = (o == 4'd5);
        is_sw = (o == 4'd6);
        if (m_halt) return;
        if (m_idle) begin
            drive(1'b1, rb(), rop(), rb(), ST_IDLE, '0, "idle_start");
            m_idle = 0;
        end
        for (int i = 1; i <= fw; i++) begin
            drive(rb(), 1'b0, rop(), rb(), ST_FETCH, sb(1,0,0,0,0,0,0,3'b000,0,0,0), "fetch_wait");
            if (i == WAIT_LIMIT) begin
                m_tmo = 1; m_halt = 1;
                return;
            end
        end
        drive(rb(), 1'b1, rop(), rb(), ST_FETCH, sb(1,0,0,1,1,0,0,3'b000,0,0,0), "fetch");
        drive(rb(), rb(), o, rb(), ST_DECODE, '0, "decode");
        if (o >= 4'd10) begin
            m_ill = 1; m_halt = 1;
            return;
        end
        if (o == 4'd8 || o == 4'd9) begin
            taken = (o == 4'd8) ? z : !z;
            drive(run_end, rb(), o, z, ST_BRANCH, sb(0,0,0,0,taken,1,0,3'b110,0,0,0), "branch");
            m_ret++; m_idle = !run_end;
            return;
        end
        drive(rb(), rb(), o, rb(), ST_EXEC,
              sb(0,0,0,0,0,0,(o >= 4'd4 && o <= 4'd6),alu_for(o),0,0,0), "exec");
        if (is_lw || is_sw) begin
            if (rst_in_mem) begin
                do_reset();
                return;
            end
            for (int i = 1; i <= mw; i++) begin
                drive(rb(), 1'b0, o, rb(), ST_MEM, sb(1,is_sw,1,0,0,0,1,3'b010,0,0,0), "mem_wait");
                if (i == WAIT_LIMIT) begin
                    m_tmo = 1; m_halt = 1;
                    return;
                end
            end
            if (is_sw) begin
                drive(run_end, 1'b1, o, rb(), ST_MEM, sb(1,1,1,0,0,0,1,3'b010,0,0,0), "mem_sw");
                m_ret++; m_idle = !run_end;
                return;
            end
            drive(rb(), 1'b1, o, rb(), ST_MEM, sb(1,0,1,0,0,0,1,3'b010,0,0,0), "mem_lw");
        end
        drive(run_end, rb(), o, rb(), ST_WB, sb(0,0,0,0,0,0,0,3'b000,is_r,is_lw,1), "wb");
        m_ret++; m_idle = !run_end;
    endtask

    // Monitor: every cycle with a queued expectation is compared mid-cycle.
    always @(negedge clk) begin
        exp_t  e;
        exp_t  g;
        string t;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            g.st = state;
            g.strb = {mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src,
                      alu_ctrl, reg_dst, mem_to_reg, reg_write};
            g.ill = illegal;
            g.tmo = timeout;
            g.ret = retired;
            checks++;
            n_seen++;
            if (g !== e) begin
                failures++;
                $display("FAIL %s #%0d: got st=%0d strb=%b ill=%b tmo=%b ret=%0d, expected st=%0d strb=%b ill=%b tmo=%b ret=%0d",
                         t, n_seen, g.st, g.strb, g.ill, g.tmo, g.ret,
                         e.st, e.strb, e.ill, e.tmo, e.ret);
            end
        end
    end

    initial begin
        do_reset();
        // Directed instructions first.
        issue(4'd0, 1'b0, 0, 0, 1'b1, 1'b0);   // add
        issue(4'd5, 1'b0, 0, 3, 1'b1, 1'b0);   // lw, 3 wait cycles in MEM
        issue(4'd6, 1'b0, 0, 1, 1'b1, 1'b0);   // sw
        issue(4'd8, 1'b1, 0, 0, 1'b1, 1'b0);   // beq taken
        issue(4'd8, 1'b0, 0, 0, 1'b1, 1'b0);   // beq not taken
        issue(4'd9, 1'b1, 0, 0, 1'b1, 1'b0);   // bne not taken
        issue(4'd9, 1'b0, 1, 0, 1'b1, 1'b0);   // bne taken
        issue(4'd0, 1'b0, 0, 0, 1'b0, 1'b0);   // run dropped: finish, then IDLE
        drive(1'b0, rb(), rop(), rb(), ST_IDLE, '0, "idle");
        issue(4'd4, 1'b0, 2, 0, 1'b1, 1'b0);   // addi from IDLE
        issue(4'd5, 1'b0, 0, 2, 1'b1, 1'b1);   // reset during MEM
        issue(4'd15, 1'b0, 0, 0, 1'b1, 1'b0);  // illegal opcode
        halt_cycles(4);
        do_reset();
        issue(4'd0, 1'b0, 6, 0, 1'b1, 1'b0);   // fetch timeout
        halt_cycles(3);
        do_reset();
        issue(4'd6, 1'b0, 0, 5, 1'b1, 1'b0);   // store timeout in MEM
        halt_cycles(2);
        do_reset();
        // Random instruction stream; retired wraps several times.
        for (int k = 0; k < 300; k++) begin
            logic [3:0] o;
            int fw, mw;
            if (m_halt) begin
                halt_cycles($urandom_range(1, 3));
                do_reset();
            end
            if (m_idle && rb())
                drive(1'b0, rb(), rop(), rb(), ST_IDLE, '0, "idle");
            o  = ($urandom_range(0, 9) < 9) ? 4'($urandom_range(0, 9)) : 4'($urandom_range(10, 15));
            fw = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 2) : $urandom_range(3, 5);
            mw = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 2) : $urandom_range(3, 5);
            issue(o, rb(), fw, mw, ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0));
        end
        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: left=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
